// File: rtl/exc_ctrl.sv
// exc_ctrl: M-stage exception/interrupt sequencer owning SR, Cause and EPC.
//   clk, reset_n                 : clock and asynchronous active-low reset
//   ExcCode_M, PC_M, BD_M, ERET_M: M-stage instruction exception info
//   HWInt                        : level-sensitive external interrupt lines
//   CP0Write, CP0Addr, CP0In     : mtc0 write port (12 SR, 13 Cause, 14 EPC)
//   CP0Out                       : mfc0 read data, combinational on CP0Addr
//   Flush, Stall                 : pipeline kill / PC and F/D freeze
//   Redirect_Valid, Redirect_PC  : fetch redirect request and target
//   Redirect_Ack                 : fetch accepted the redirect
//   EPC_Out                      : current EPC
module exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ExcCode_M,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic        ERET_M,
    input  logic [5:0]  HWInt,
    input  logic        CP0Write,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    output logic        Flush,
    output logic        Stall,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    input  logic        Redirect_Ack,
    output logic [31:0] EPC_Out
);
    localparam logic [4:0] NO_EXC_CODE = 5'd31;
    localparam logic [4:0] EXC_INT     = 5'd0;

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [5:0]  im_q, im_d, ip_q, ip_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d, target_q, target_d;
    logic [31:0] epc_take, sr, cause;
    logic        int_req, exc_req;

    assign int_req  = ie_q & ~exl_q & |(im_q & HWInt);
    assign exc_req  = ExcCode_M != NO_EXC_CODE;
    assign epc_take = BD_M ? PC_M - 32'd4 : PC_M;

    assign sr    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};

    assign CP0Out = CP0Addr == 5'd12 ? sr :
                    CP0Addr == 5'd13 ? cause :
                    CP0Addr == 5'd14 ? epc_q : 32'd0;

    assign Flush          = state_q == FLUSH;
    assign Stall          = state_q != IDLE;
    assign Redirect_Valid = state_q == REDIRECT;
    assign Redirect_PC    = target_q;
    assign EPC_Out        = epc_q;

    always_comb begin
        state_d  = state_q;
        im_d     = im_q;
        exl_d    = exl_q;
        ie_d     = ie_q;
        bd_d     = bd_q;
        exc_d    = exc_q;
        epc_d    = epc_q;
        target_d = target_q;
        ip_d     = HWInt;
        case (state_q)
            IDLE: begin
                if (int_req || exc_req) begin
                    exl_d    = 1'b1;
                    exc_d    = int_req ? EXC_INT : ExcCode_M;
                    bd_d     = BD_M;
                    epc_d    = {epc_take[31:2], 2'b00};
                    target_d = HANDLER_PC;
                    state_d  = FLUSH;
                end else if (ERET_M) begin
                    exl_d    = 1'b0;
                    target_d = epc_q;
                    state_d  = FLUSH;
                end else if (CP0Write) begin
                    // Cause is read-only to software; only SR and EPC accept writes.
                    if (CP0Addr == 5'd12) begin
                        im_d  = CP0In[15:10];
                        exl_d = CP0In[1];
                        ie_d  = CP0In[0];
                    end else if (CP0Addr == 5'd14) begin
                        epc_d = {CP0In[31:2], 2'b00};
                    end
                end
            end
            FLUSH:    state_d = REDIRECT;
            REDIRECT: state_d = Redirect_Ack ? IDLE : REDIRECT;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            im_q     <= '0;
            ip_q     <= '0;
            exl_q    <= 1'b0;
            ie_q     <= 1'b0;
            bd_q     <= 1'b0;
            exc_q    <= '0;
            epc_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            im_q     <= im_d;
            ip_q     <= ip_d;
            exl_q    <= exl_d;
            ie_q     <= ie_d;
            bd_q     <= bd_d;
            exc_q    <= exc_d;
            epc_q    <= epc_d;
            target_q <= target_d;
        end
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the five-stage MIPS pipeline. Sits at the M stage and consumes the final per-instruction exception code produced by the ExcCode chain (F→D→E→M), plus external hardware interrupts and `eret`. It owns the SR, Cause and EPC registers, decides when to take an exception, and drives a three-state flush/redirect sequence to the fetch stage.

## Interface
Parameters:
- HANDLER_PC, 32'h0000_4180, exception handler entry address
- No parameter overrides exception code values; codes come from `Exception_Code.v` (`No_ExcCode`, `ExcCode_Int`=0, `ExcCode_Syscall`=8, `ExcCode_RI`=10)

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ExcCode_M  in  5  exception code of the M-stage instruction, `No_ExcCode` if none
- PC_M  in  32  M-stage PC
- BD_M  in  1  M-stage instruction is in a branch delay slot
- ERET_M  in  1  M-stage instruction is `eret`
- HWInt  in  6  external interrupt lines, level-sensitive
- CP0Write  in  1  `mtc0` in M stage
- CP0Addr  in  5  CP0 register number (12 SR, 13 Cause, 14 EPC)
- CP0In  in  32  `mtc0` data
- CP0Out  out  32  `mfc0` read data, combinational on CP0Addr; 0 for unmapped numbers
- Flush  out  1  kill all instructions in F/D/E/M
- Stall  out  1  freeze PC and F/D register
- Redirect_Valid  out  1  Redirect_PC is to be loaded into PC
- Redirect_PC  out  32  target address
- Redirect_Ack  in  1  fetch stage accepted the redirect this cycle
- EPC_Out  out  32  current EPC

## Operation
- Registers: SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC 32 bits, bits [1:0] forced 0.
- Cause.IP sampled from HWInt every cycle regardless of state.
- IntReq = IE & ~EXL & |(IM & HWInt). ExcReq = ExcCode_M != `No_ExcCode`.
- Priority in IDLE: IntReq > ExcReq > ERET_M > CP0Write.
- Take (IntReq or ExcReq): EXL←1; Cause.ExcCode←0 (interrupt) or ExcCode_M; Cause.BD←BD_M; EPC←BD_M ? PC_M−4 : PC_M (32-bit wrap); target←HANDLER_PC; go FLUSH.
- ERET_M (no Int/Exc): EXL←0; target←EPC; go FLUSH.
- CP0Write applies only in IDLE with no take/eret: writes SR (IM, EXL, IE only) or EPC; Cause writes ignored. Dropped if a take/eret occurs in the same cycle.
- States: IDLE → FLUSH (1 cycle, Flush=1, Stall=1) → REDIRECT (Redirect_Valid=1, Stall=1, Redirect_PC=target held stable) → IDLE on Redirect_Ack.
- In FLUSH/REDIRECT: ExcCode_M, ERET_M, CP0Write, IntReq ignored (instructions are being killed); IP still updates.
- Redirect_Ack outside REDIRECT ignored.

## Timing
- Reset (async, reset_n low): state IDLE; SR=0, Cause=0, EPC=0, target=0; Flush=0, Stall=0, Redirect_Valid=0, Redirect_PC=0, EPC_Out=0. Reset mid-sequence aborts it immediately.
- Decision combinational on cycle N inputs; registers update at edge N; Flush high in cycle N+1; Redirect_Valid high from N+2 until the cycle Redirect_Ack is sampled high (inclusive); IDLE at N+3 earliest.
- Minimum spacing between two takes: 3 cycles.
- CP0Out reflects writes from the following cycle (no bypass).
- Interrupt arriving with IE set by `mtc0` in cycle N: earliest take cycle N+1.

## Test plan
- Syscall: ExcCode_M=8, PC_M=0x3010, BD_M=0 → EPC=0x3010, Cause.ExcCode=8, EXL=1, Flush one cycle, Redirect_PC=0x4180 until Ack.
- Delay-slot RI: ExcCode_M=10, PC_M=0x3020, BD_M=1 → EPC=0x301C, Cause=0x8000_0028.
- Interrupt: SR=0x0000_0401, HWInt=6'b000001 → take with ExcCode 0; same with EXL=1 or IE=0 → no take; Cause.IP=1 either way.
- Simultaneous: IntReq, ExcCode_M=8, CP0Write to EPC same cycle → interrupt taken, EPC=PC_M, write dropped.
- ERET: EPC=0x3040, ERET_M=1 → EXL←0, Redirect_PC=0x3040; Ack delayed 3 cycles → Redirect_Valid/Stall held, new ExcCode_M ignored.
- reset_n pulsed low during REDIRECT → all outputs 0 asynchronously, IDLE after release.
